// File: rtl/priority_encoder_4to2.sv
// priority_encoder_4to2: 4-to-2 priority encoder feeding a 2-entry result FIFO with a saturating error counter
module priority_encoder_4to2 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       W,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [1:0]       Y,
   output logic             V,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] err_cnt
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t     state, state_nx;
   logic [3:0] head, tail, head_nx, tail_nx, enc;
   logic [1:0] enc_y;
   logic       enc_v, enc_err, push, pop;
   assign in_ready  = state != FULL;
   assign out_valid = state != EMPTY;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign enc       = {enc_y, enc_v, enc_err};
   assign {Y, V, err} = out_valid ? head : 4'b0000;
   // encode the incoming word, highest set bit wins; multi-hot flagged as an error
   always_comb begin
      enc_y   = W[3] ? 2'd3 : W[2] ? 2'd2 : W[1] ? 2'd1 : 2'd0;
      enc_v   = |W;
      enc_err = (W & (W - 4'd1)) != 4'd0;
   end
   // occupancy transitions; head is the oldest entry, tail only used when full
   always_comb begin
      state_nx = state;
      head_nx  = head;
      tail_nx  = tail;
      case (state)
         EMPTY: if (push) begin
            state_nx = ONE;
            head_nx  = enc;
         end
         ONE: if (push && pop) begin
            head_nx = enc;
         end else if (push) begin
            state_nx = FULL;
            tail_nx  = enc;
         end else if (pop) begin
            state_nx = EMPTY;
         end
         FULL: if (pop) begin
            state_nx = ONE;
            head_nx  = tail;
         end
         default: state_nx = EMPTY;
      endcase
   end
   // state, storage and error counter registers; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= EMPTY;
         head    <= 4'b0000;
         tail    <= 4'b0000;
         err_cnt <= '0;
      end else begin
         state <= state_nx;
         head  <= head_nx;
         tail  <= tail_nx;
         if (push && enc_err && err_cnt != {CNT_W{1'b1}})
            err_cnt <= err_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_priority_encoder_4to2.sv
// tb_priority_encoder_4to2: directed table-driven check of the encoder FIFO and its error counter
module tb_priority_encoder_4to2;
   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready;
   logic [3:0] w;
   logic       in_ready, v, err, out_valid;
   logic [1:0] y;
   logic [7:0] err_cnt;
   logic       s_in_ready, s_v, s_err, s_out_valid;
   logic [1:0] s_y;
   logic [1:0] s_err_cnt;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] w;
      logic       iv, ordy, ir, ov;
      logic [1:0] y;
      logic       v, e;
      int         cnt;
   } vec_t;
   vec_t tbl[13];

   priority_encoder_4to2 dut (
      .clk(clk), .rst(rst), .W(w), .in_valid(in_valid), .in_ready(in_ready),
      .Y(y), .V(v), .err(err), .out_valid(out_valid), .out_ready(out_ready),
      .err_cnt(err_cnt)
   );

   priority_encoder_4to2 #(.CNT_W(2)) sat (
      .clk(clk), .rst(rst), .W(w), .in_valid(in_valid), .in_ready(s_in_ready),
      .Y(s_y), .V(s_v), .err(s_err), .out_valid(s_out_valid), .out_ready(out_ready),
      .err_cnt(s_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ir, input logic ov,
                          input logic [1:0] ey, input logic ev, input logic ee, input int ec);
      chk({tag, " in_ready"}, int'(in_ready), int'(ir));
      chk({tag, " out_valid"}, int'(out_valid), int'(ov));
      chk({tag, " Y"}, int'(y), int'(ey));
      chk({tag, " V"}, int'(v), int'(ev));
      chk({tag, " err"}, int'(err), int'(ee));
      chk({tag, " err_cnt"}, int'(err_cnt), ec);
   endtask

   initial begin
      // single words, then simultaneous push/pop in ONE, multi-hot and zero words, drain
      tbl[0]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 0};
      tbl[1]  = '{4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 0};
      tbl[2]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 0};
      tbl[3]  = '{4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 0};
      tbl[4]  = '{4'b1010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1};
      tbl[5]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1};
      tbl[6]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1};
      // backpressure: fill, stall a third word, then drain in order
      tbl[7]  = '{4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1};
      tbl[8]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1};
      tbl[9]  = '{4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1};
      tbl[10] = '{4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1};
      tbl[11] = '{4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1};
      tbl[12] = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1};

      rst = 1'b1; w = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
      step();
      step();
      chk_all("reset", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0);
      rst = 1'b0; in_valid = 1'b0; w = 4'b0000;
      step();
      chk_all("idle", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0);

      for (int i = 0; i < 13; i++) begin
         w = tbl[i].w; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].y, tbl[i].v, tbl[i].e, tbl[i].cnt);
      end

      // fill to FULL with err_cnt=2, then reset with transfers pending
      w = 4'b0011; in_valid = 1'b1; out_ready = 1'b0;
      step();
      w = 4'b0001;
      step();
      chk_all("full", 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 2);
      rst = 1'b1; w = 4'b1100; out_ready = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk_all("rst_mid", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0);
      chk("rst_mid sat_cnt", int'(s_err_cnt), 0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk_all($sformatf("no_stale%0d", i), 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0);
      end

      // five multi-hot words into both counters; the 2-bit one saturates at 3
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         w = (i % 2 == 0) ? 4'b1100 : 4'b0111;
         step();
         chk($sformatf("sat_cnt%0d", i), int'(s_err_cnt), (i < 3) ? i + 1 : 3);
         chk($sformatf("wide_cnt%0d", i), int'(err_cnt), i + 1);
         chk($sformatf("sat_err%0d", i), int'(s_err), 1);
      end
      in_valid = 1'b0;
      step();
      chk("sat_drain out_valid", int'(s_out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/priority_encoder_4to2.md
PRIORITY_ENCODER_4TO2 -- requirements
Module: priority_encoder_4to2

Interface
REQ-001 Parameter CNT_W, default 8: width of the error counter.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 W  input  4  one-hot request word to encode.
REQ-005 in_valid  input  1  W is valid this cycle.
REQ-006 in_ready  output  1  block can accept W this cycle.
REQ-007 Y  output  2  encoded index of the highest set bit of the head entry.
REQ-008 V  output  1  head entry had at least one bit set.
REQ-009 err  output  1  head entry had more than one bit set.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_ready  input  1  downstream accepts the head entry this cycle.
REQ-012 err_cnt  output  CNT_W  saturating count of accepted multi-hot words.

Function
REQ-013 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-014 An output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-015 Encoding SHALL follow priority order, highest bit first:
- W[3]=1 gives Y=3.
- else W[2]=1 gives Y=2.
- else W[1]=1 gives Y=1.
- else Y=0.
REQ-016 V SHALL be 1 when W is nonzero; err SHALL be 1 when two or more bits of W are set.
REQ-017 W=4'b0000 SHALL encode as Y=0, V=0, err=0 and SHALL still be transferred as a valid entry.
REQ-018 Encoded results {Y,V,err} SHALL be stored in a 2-entry FIFO and presented in acceptance order.
REQ-019 The FIFO SHALL have three occupancy states: EMPTY, ONE and FULL.
REQ-020 FIFO state transitions SHALL be:
- EMPTY to ONE on push.
- ONE to FULL on push without pop.
- ONE to EMPTY on pop without push.
- ONE stays ONE on simultaneous push and pop.
- FULL to ONE on pop.
REQ-021 in_ready SHALL be 1 in states EMPTY and ONE and 0 in FULL, and SHALL be a function of registered state only.
REQ-022 out_valid SHALL be 1 in states ONE and FULL.
REQ-023 Latency: a word accepted at edge n while EMPTY SHALL appear with out_valid=1 after edge n.
REQ-024 Y, V and err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 In state FULL, a pop with in_valid=1 SHALL NOT accept the input that cycle; the input is accepted on the next edge.
REQ-026 In state ONE with simultaneous push and pop, the new entry SHALL become the head after the edge.
REQ-027 Counter rules:
- err_cnt SHALL increment by 1 on every input transfer with err=1.
- err_cnt SHALL hold at 2^CNT_W-1 once that value is reached.
- err_cnt SHALL increment at acceptance time, independent of the output side.
REQ-028 When out_valid=0, Y, V and err SHALL read 0.

Reset
REQ-029 While rst=1 at a rising edge, the FIFO SHALL go to EMPTY and err_cnt to 0, and all stored entries SHALL be discarded.
REQ-030 Reset values SHALL be out_valid=0, Y=0, V=0, err=0, err_cnt=0, with in_ready=1 from the first edge after rst deasserts.
REQ-031 rst SHALL take priority over simultaneous input or output transfers, and any entry in flight SHALL be lost.

Verification
REQ-032 Single-word latency and one-hot encode:
- Stimulus: out_ready=1; W=4'b0001, then 0010, 0100, 1000, one per cycle.
- Response: Y=0,1,2,3 with V=1 and err=0, each one cycle after acceptance.
REQ-033 Multi-hot and zero inputs:
- Stimulus: W=4'b1010, then W=4'b0000.
- Response: Y=3, V=1, err=1, err_cnt=1; then Y=0, V=0, err=0, err_cnt unchanged.
REQ-034 Backpressure:
- Stimulus: out_ready=0; present W=0001, 0100, 1000 on consecutive cycles.
- Response: the first two words are accepted and in_ready=0 after the second; out_valid=1 with Y=0 held stable.
- Stimulus: then out_ready=1.
- Response: outputs Y=0, 2, 3 in order, with no loss or duplication.
REQ-035 Simultaneous push and pop:
- Stimulus: in state ONE, in_valid=1 and out_ready=1 for 4 cycles.
- Response: state stays ONE, one output per cycle, in_ready=1 throughout.
REQ-036 Counter saturation:
- Stimulus: CNT_W=2; 5 multi-hot words.
- Response: err_cnt reads 1, 2, 3, 3, 3.
REQ-037 Reset mid-operation:
- Stimulus: state FULL with err_cnt=2; assert rst for one cycle.
- Response: out_valid=0, err_cnt=0, in_ready=1 on the next cycle; no stale entries appear afterwards.
